radio_sample_averager: RTL and testbench

RADIO_SAMPLE_AVERAGER -- requirements
Module: radio_sample_averager

---
 rtl/radio_pkg.sv | 25 ++
 rtl/radio_sample_averager_if.sv | 48 ++++
 rtl/stream_word_sink.sv | 42 ++++
 rtl/radio_sample_averager.sv | 127 ++++++++++++
 tb/tb_radio_sample_averager.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/radio_pkg.sv
// ------------------------------------------------------------------
// radio_pkg : shared widths, output state encoding and shift clamp.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package radio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int ACC_W     = 32;
  localparam int SHIFT_MAX = 15;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Exponents that do not fit in four bits saturate to the longest block.
  function automatic logic [3:0] clamp_shift(input logic [ACC_W-1:0] value);
    return (value[ACC_W-1:4] == '0) ? value[3:0] : 4'(SHIFT_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/radio_sample_averager_if.sv
// ------------------------------------------------------------------
// radio_sample_averager_if : config, sample and audio-output bundle.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface radio_sample_averager_if;
  import radio_pkg::*;

  logic [ACC_W-1:0]    input_frequency;
  logic                input_frequency_stb;
  logic                input_frequency_ack;
  logic [ACC_W-1:0]    input_average_samples;
  logic                input_average_samples_stb;
  logic                input_average_samples_ack;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_in_valid;
  logic [ACC_W-1:0]    output_audio;
  logic                output_audio_stb;
  logic                output_audio_ack;
  logic [ACC_W-1:0]    phase_inc;
  logic                overrun;

  modport master (
    output input_frequency, input_frequency_stb,
    input  input_frequency_ack,
    output input_average_samples, input_average_samples_stb,
    input  input_average_samples_ack,
    output sample_in, sample_in_valid,
    input  output_audio, output_audio_stb,
    output output_audio_ack,
    input  phase_inc, overrun
  );

  modport slave (
    input  input_frequency, input_frequency_stb,
    output input_frequency_ack,
    input  input_average_samples, input_average_samples_stb,
    output input_average_samples_ack,
    input  sample_in, sample_in_valid,
    output output_audio, output_audio_stb,
    input  output_audio_ack,
    output phase_inc, overrun
  );

endinterface

`default_nettype wire

// File: rtl/stream_word_sink.sv
// ------------------------------------------------------------------
// stream_word_sink : one-word acceptor with registered ack; holds last word.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module stream_word_sink #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stb,
  input  logic [WIDTH-1:0] data,
  output logic             ack,
  output logic [WIDTH-1:0] word
);

  logic             ack_q, ack_d;
  logic [WIDTH-1:0] word_q, word_d;

  // Ack is forced low for a cycle after each transfer.
  always_comb begin
    ack_d  = stb && !ack_q;
    word_d = (stb && ack_q) ? data : word_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q  <= 1'b0;
      word_q <= '0;
    end else begin
      ack_q  <= ack_d;
      word_q <= word_d;
    end
  end

  assign ack  = ack_q;
  assign word = word_q;

endmodule

`default_nettype wire

// File: rtl/radio_sample_averager.sv
// ------------------------------------------------------------------
// radio_sample_averager : 2^shift block averager with one-word output.
// Optional rounding: define RADIO_AVG_ROUND_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module radio_sample_averager
  import radio_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  radio_sample_averager_if.slave  bus
);

  logic [ACC_W-1:0] freq_word;
  logic [ACC_W-1:0] avg_word;

  stream_word_sink #(.WIDTH(ACC_W)) u_freq_sink (
    .clk  (clk),
    .rst  (rst),
    .stb  (bus.input_frequency_stb),
    .data (bus.input_frequency),
    .ack  (bus.input_frequency_ack),
    .word (freq_word)
  );

  stream_word_sink #(.WIDTH(ACC_W)) u_avg_sink (
    .clk  (clk),
    .rst  (rst),
    .stb  (bus.input_average_samples_stb),
    .data (bus.input_average_samples),
    .ack  (bus.input_average_samples_ack),
    .word (avg_word)
  );

  assign bus.phase_inc = freq_word;

  // The exponent register updates on the same edge that clears the block.
  logic [3:0] shift;
  logic       avg_xfer;
  assign shift    = clamp_shift(avg_word);
  assign avg_xfer = bus.input_average_samples_stb && bus.input_average_samples_ack;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SHIFT_MAX-1:0]    count_q, count_d;
  logic [ACC_W-1:0]        audio_q, audio_d;
  logic                    overrun_q, overrun_d;
  out_state_e              state_q, state_d;

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] result;
  logic [SHIFT_MAX:0]      limit;
  logic                    complete;
  logic                    out_ack;
  logic                    out_take;

  always_comb begin
    sum      = acc_q + {{(ACC_W-SAMPLE_W){bus.sample_in[SAMPLE_W-1]}}, bus.sample_in};
    limit    = ((SHIFT_MAX+1)'(1) << shift) - (SHIFT_MAX+1)'(1);
    complete = bus.sample_in_valid && !avg_xfer && ({1'b0, count_q} == limit);
`ifdef RADIO_AVG_ROUND_EN
    biased   = (shift != 4'd0) ? sum + (ACC_W'(1) << (shift - 4'd1)) : sum;
`else
    biased   = sum;
`endif
    result   = biased >>> shift;
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (avg_xfer || complete) begin
      acc_d   = '0;
      count_d = '0;
    end else if (bus.sample_in_valid) begin
      acc_d   = sum;
      count_d = count_q + SHIFT_MAX'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (complete) state_d = FULL;
      FULL:    if (bus.output_audio_ack && !complete) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // A completion in FULL is only accepted if the held word leaves this cycle.
  always_comb begin
    out_ack   = (state_q == FULL) && bus.output_audio_ack;
    out_take  = complete && ((state_q == EMPTY) || out_ack);
    overrun_d = complete && (state_q == FULL) && !out_ack;
    audio_d   = out_take ? result : audio_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      audio_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      count_q   <= count_d;
      audio_q   <= audio_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.output_audio     = audio_q;
  assign bus.output_audio_stb = (state_q == FULL);
  assign bus.overrun          = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_radio_sample_averager.sv
// ------------------------------------------------------------------
// tb_radio_sample_averager : directed and random checks against a block-average model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_radio_sample_averager;

  logic clk;
  logic rst;

  radio_sample_averager_if ifc ();

  radio_sample_averager dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err;
  int n_checks;

  // Reference state: acks, held output word, current block contents.
  bit          m_fack;
  bit          m_aack;
  logic [31:0] m_phase;
  bit          m_full;
  logic [31:0] m_word;
  bit          m_ovr;
  int          m_shift;
  int          m_blk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fack  = 0;
    m_aack  = 0;
    m_phase = '0;
    m_full  = 0;
    m_word  = '0;
    m_ovr   = 0;
    m_shift = 0;
    m_blk.delete();
  endtask

  // Mean of the block, rounded down (or half-up when rounding is built in).
  function automatic logic [31:0] blk_avg(input int sh);
    longint s;
    longint d;
    longint q;
    s = 0;
    foreach (m_blk[i]) s += m_blk[i];
`ifdef RADIO_AVG_ROUND_EN
    if (sh > 0) s += (longint'(1) << (sh - 1));
`endif
    d = longint'(1) << sh;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q -= 1;
    return q[31:0];
  endfunction

  task automatic check_all();
    chk("freq_ack",  {31'b0, ifc.input_frequency_ack},       {31'b0, m_fack});
    chk("avg_ack",   {31'b0, ifc.input_average_samples_ack}, {31'b0, m_aack});
    chk("audio_stb", {31'b0, ifc.output_audio_stb},          {31'b0, m_full});
    chk("audio",     ifc.output_audio,                       m_word);
    chk("phase_inc", ifc.phase_inc,                          m_phase);
    chk("overrun",   {31'b0, ifc.overrun},                   {31'b0, m_ovr});
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT and compare.
  task automatic step();
    bit          fx, ax, done, take;
    logic [31:0] r;
    fx   = ifc.input_frequency_stb && m_fack;
    ax   = ifc.input_average_samples_stb && m_aack;
    m_fack = ifc.input_frequency_stb && !m_fack;
    m_aack = ifc.input_average_samples_stb && !m_aack;
    if (fx) m_phase = ifc.input_frequency;
    done = 0;
    r    = '0;
    m_ovr = 0;
    if (ax) begin
      m_blk.delete();
    end else if (ifc.sample_in_valid) begin
      m_blk.push_back(int'($signed(ifc.sample_in)));
      if (m_blk.size() == (1 << m_shift)) begin
        r    = blk_avg(m_shift);
        done = 1;
        m_blk.delete();
      end
    end
    if (ax) m_shift = (ifc.input_average_samples > 32'd15) ? 15 : int'(ifc.input_average_samples);
    take = ifc.output_audio_ack && m_full;
    if (done) begin
      if (!m_full || take) begin
        m_word = r;
        m_full = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (take) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [15:0] s);
    ifc.sample_in_valid = 1'b1;
    ifc.sample_in       = s;
    step();
    ifc.sample_in_valid = 1'b0;
  endtask

  task automatic set_avg(input logic [31:0] v, input bit with_sample, input logic [15:0] s);
    ifc.input_average_samples_stb = 1'b1;
    ifc.input_average_samples     = v;
    step();
    if (with_sample) begin
      ifc.sample_in_valid = 1'b1;
      ifc.sample_in       = s;
    end
    step();
    ifc.sample_in_valid           = 1'b0;
    ifc.input_average_samples_stb = 1'b0;
  endtask

  task automatic ack_out();
    ifc.output_audio_ack = 1'b1;
    step();
    ifc.output_audio_ack = 1'b0;
  endtask

  task automatic idle_inputs();
    ifc.input_frequency           = '0;
    ifc.input_frequency_stb       = 1'b0;
    ifc.input_average_samples     = '0;
    ifc.input_average_samples_stb = 1'b0;
    ifc.sample_in                 = '0;
    ifc.sample_in_valid           = 1'b0;
    ifc.output_audio_ack          = 1'b0;
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    rst      = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Frequency handshake and phase increment
    ifc.input_frequency_stb = 1'b1;
    ifc.input_frequency     = 32'h0123_4567;
    step();
    chk("freq_ack_rise", {31'b0, ifc.input_frequency_ack}, 32'd1);
    step();
    ifc.input_frequency_stb = 1'b0;
    chk("phase_loaded", ifc.phase_inc, 32'h0123_4567);

    // Single-sample block with most negative input
    send(16'h8000);
    chk("neg_stb", {31'b0, ifc.output_audio_stb}, 32'd1);
    chk("neg_word", ifc.output_audio, 32'hFFFF_8000);
    ack_out();
    chk("neg_acked", {31'b0, ifc.output_audio_stb}, 32'd0);

    // Four-sample blocks
    set_avg(32'd2, 1'b0, 16'd0);
    send(16'd1); send(16'd2); send(16'd3);
    chk("blk4_not_yet", {31'b0, ifc.output_audio_stb}, 32'd0);
    send(16'd4);
`ifdef RADIO_AVG_ROUND_EN
    chk("blk4_pos", ifc.output_audio, 32'd3);
`else
    chk("blk4_pos", ifc.output_audio, 32'd2);
`endif
    ack_out();
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF); send(16'hFFFE);
`ifdef RADIO_AVG_ROUND_EN
    chk("blk4_neg", ifc.output_audio, 32'hFFFF_FFFF);
`else
    chk("blk4_neg", ifc.output_audio, 32'hFFFF_FFFE);
`endif
    ack_out();

    // Overrun, then completion coinciding with ack
    set_avg(32'd0, 1'b0, 16'd0);
    send(16'd5);
    send(16'd7);
    chk("ovr_pulse", {31'b0, ifc.overrun}, 32'd1);
    chk("ovr_kept", ifc.output_audio, 32'd5);
    step();
    chk("ovr_single", {31'b0, ifc.overrun}, 32'd0);
    ifc.output_audio_ack = 1'b1;
    send(16'd7);
    ifc.output_audio_ack = 1'b0;
    chk("ack_cmpl_word", ifc.output_audio, 32'd7);
    chk("ack_cmpl_stb", {31'b0, ifc.output_audio_stb}, 32'd1);
    chk("ack_cmpl_novr", {31'b0, ifc.overrun}, 32'd0);
    ack_out();

    // Clamped exponent, then restart with a pending word held
    set_avg(32'h20, 1'b0, 16'd0);
    send(16'd9); send(16'd9); send(16'd9);
    chk("clamp_no_out", {31'b0, ifc.output_audio_stb}, 32'd0);
    set_avg(32'd0, 1'b0, 16'd0);
    send(16'd11);
    set_avg(32'd1, 1'b0, 16'd0);
    send(16'd100);
    set_avg(32'd1, 1'b1, 16'd55);
    chk("restart_kept", ifc.output_audio, 32'd11);
    ack_out();
    send(16'd20);
    send(16'd30);
    chk("restart_blk", ifc.output_audio, 32'd25);
    ack_out();

    // Asynchronous reset while FULL with a half block accumulated
    set_avg(32'd1, 1'b0, 16'd0);
    send(16'd1); send(16'd3);
    send(16'd5);
    chk("pre_rst_full", {31'b0, ifc.output_audio_stb}, 32'd1);
    #2;
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    send(16'd9);
    chk("post_rst_word", ifc.output_audio, 32'd9);
    ack_out();

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      int pick;
      ifc.input_frequency_stb = ($urandom_range(0, 4) == 0);
      ifc.input_frequency     = $urandom;
      ifc.input_average_samples_stb = ($urandom_range(0, 19) == 0);
      pick = $urandom_range(0, 9);
      if (pick < 8)       ifc.input_average_samples = 32'($urandom_range(0, 3));
      else if (pick == 8) ifc.input_average_samples = 32'h100;
      else                ifc.input_average_samples = 32'($urandom_range(0, 15));
      ifc.sample_in_valid  = ($urandom_range(0, 2) != 0);
      ifc.sample_in        = 16'($urandom);
      ifc.output_audio_ack = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
